// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer and its helpers.
// Holds the FSM state encoding and the default / simulation counter depths.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  // 1_000_000 samples is 10 ms at a 100 MHz system clock
  localparam int DEFAULT_CNT_MAX     = 1000000;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int SIM_CNT_MAX         = 4;

endpackage

// File: rtl/btn_debouncer_sync_ff.sv
// N-stage single-bit synchroniser for asynchronous board inputs.
// Synchronous active-high reset clears every stage to 0; STAGES must be >= 2.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/btn_debouncer.sv
// Debounces a raw button input: synchroniser, counter-qualified FSM, registered level and edge pulses.
// Optional macro DEBOUNCE_TOGGLE_EN adds a toggle register flipped on every rising pulse.
module btn_debouncer
  import debounce_pkg::*;
#(
  parameter int CNT_MAX     = DEFAULT_CNT_MAX,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_toggle
);

  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit ACCEPT_ON_FIRST = (CNT_MAX == 1);

  logic             w_s;
  db_state_t        r_state;
  db_state_t        w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_level;
  logic             w_levelNext;
  logic             r_rise;
  logic             w_riseNext;
  logic             r_fall;
  logic             w_fallNext;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(btn_in),
    .o_q(w_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_level <= w_levelNext;
      r_rise  <= w_riseNext;
      r_fall  <= w_fallNext;
    end
  end

  // Pulses default low so they can only last the single cycle after an accept
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_levelNext = r_level;
    w_riseNext  = 1'b0;
    w_fallNext  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        w_cntNext = '0;
        if (w_s) begin
          if (ACCEPT_ON_FIRST) begin
            w_stateNext = IDLE_HIGH;
            w_levelNext = 1'b1;
            w_riseNext  = 1'b1;
          end else begin
            w_stateNext = WAIT_HIGH;
            w_cntNext   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!w_s) begin
          w_stateNext = IDLE_LOW;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext = IDLE_HIGH;
          w_cntNext   = '0;
          w_levelNext = 1'b1;
          w_riseNext  = 1'b1;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        w_cntNext = '0;
        if (!w_s) begin
          if (ACCEPT_ON_FIRST) begin
            w_stateNext = IDLE_LOW;
            w_levelNext = 1'b0;
            w_fallNext  = 1'b1;
          end else begin
            w_stateNext = WAIT_LOW;
            w_cntNext   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (w_s) begin
          w_stateNext = IDLE_HIGH;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext = IDLE_LOW;
          w_cntNext   = '0;
          w_levelNext = 1'b0;
          w_fallNext  = 1'b1;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_stateNext = IDLE_LOW;
        w_cntNext   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_TOGGLE_EN
  logic r_toggle;

  // Flips on the same edge that raises btn_rise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggle <= 1'b0;
    end else if (w_riseNext) begin
      r_toggle <= ~r_toggle;
    end
  end

  assign btn_toggle = r_toggle;
`else
  assign btn_toggle = 1'b0;
`endif

  assign btn_level = r_level;
  assign btn_rise  = r_rise;
  assign btn_fall  = r_fall;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed self-checking bench for btn_debouncer with CNT_MAX=4, SYNC_STAGES=2.
// Expected toggle behaviour follows DEBOUNCE_TOGGLE_EN when the bench is built with it.
module tb_btn_debouncer;
  import debounce_pkg::*;

`ifdef DEBOUNCE_TOGGLE_EN
  localparam bit TOGGLE_EN = 1'b1;
`else
  localparam bit TOGGLE_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic btn_toggle;

  int   compared;
  int   mismatched;
  logic expToggle;

  btn_debouncer #(
    .CNT_MAX(SIM_CNT_MAX),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_toggle(btn_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic inBtn, input logic inRst);
    btn_in = inBtn;
    rst    = inRst;
  endtask

  // Compares {level, rise, fall, toggle} against the expected tuple
  task automatic checkOutput(input string tag, input logic eLevel, input logic eRise,
                             input logic eFall);
    logic [3:0] observed;
    logic [3:0] expected;
    observed = {btn_level, btn_rise, btn_fall, btn_toggle};
    expected = {eLevel, eRise, eFall, (TOGGLE_EN ? expToggle : 1'b0)};
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed lvl/rise/fall/tog=%b expected=%b", tag, observed,
             expected);
    end
  endtask

  task automatic runEdges(input string tag, input int n, input logic eLevel,
                          input logic eRise, input logic eFall);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag, eLevel, eRise, eFall);
    end
  endtask

  task automatic expectRise(input string tag);
    tick();
    expToggle = ~expToggle;
    checkOutput(tag, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic cleanPress(input string tag);
    applyStimulus(1'b1, 1'b0);
    runEdges({tag, "_wait"}, 5, 1'b0, 1'b0, 1'b0);
    expectRise({tag, "_rise"});
    runEdges({tag, "_after"}, 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic cleanRelease(input string tag);
    applyStimulus(1'b0, 1'b0);
    runEdges({tag, "_wait"}, 5, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput({tag, "_fall"}, 1'b0, 1'b0, 1'b1);
    runEdges({tag, "_after"}, 2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [5:0] bounce;
    compared   = 0;
    mismatched = 0;
    expToggle  = 1'b0;

    // Reset held three cycles with the button already high
    applyStimulus(1'b1, 1'b1);
    runEdges("reset_hi", 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    runEdges("post_reset_wait", 5, 1'b0, 1'b0, 1'b0);
    expectRise("post_reset_rise");
    runEdges("post_reset_hold", 2, 1'b1, 1'b0, 1'b0);

    cleanRelease("release1");
    cleanPress("press1");

    // Three-cycle low glitch while high must be rejected
    applyStimulus(1'b0, 1'b0);
    runEdges("glitch_lo", 3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    runEdges("glitch_lo_after", 8, 1'b1, 1'b0, 1'b0);

    cleanRelease("release2");

    // Bounce 1,1,0,0,1,0 then held high
    bounce = 6'b110010;
    for (int i = 5; i >= 0; i--) begin
      applyStimulus(bounce[i], 1'b0);
      runEdges("bounce", 1, 1'b0, 1'b0, 1'b0);
    end
    cleanPress("bounce_settle");

    cleanRelease("release3");

    // Reset hits while in WAIT_HIGH with cnt=2
    applyStimulus(1'b1, 1'b0);
    runEdges("midcount_wait", 4, 1'b0, 1'b0, 1'b0);
    compared++;
    assert (dut.r_cnt === 3'd2)
    else begin
      mismatched++;
      $error("[TB] FAIL midcount_cnt_pre: observed=%0d expected=2", dut.r_cnt);
    end
    applyStimulus(1'b1, 1'b1);
    tick();
    expToggle = 1'b0;
    checkOutput("midcount_reset", 1'b0, 1'b0, 1'b0);
    compared++;
    assert (dut.r_cnt === 3'd0)
    else begin
      mismatched++;
      $error("[TB] FAIL midcount_cnt_reset: observed=%0d expected=0", dut.r_cnt);
    end
    cleanPress("midcount_restart");

    // Three clean presses for the toggle output
    cleanRelease("tog_rel1");
    cleanPress("tog_press1");
    cleanRelease("tog_rel2");
    cleanPress("tog_press2");
    cleanRelease("tog_rel3");
    cleanPress("tog_press3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
